// File: rtl/lsu1_c_pkg.sv
// Shared load/store definitions: LS_SEL codes, access size codes and LSU state encoding.
package lsu1_c_pkg;

    localparam logic [3:0] LS_SEL_LB  = 4'h0;
    localparam logic [3:0] LS_SEL_LBU = 4'h1;
    localparam logic [3:0] LS_SEL_LH  = 4'h2;
    localparam logic [3:0] LS_SEL_LHU = 4'h3;
    localparam logic [3:0] LS_SEL_LW  = 4'h4;
    localparam logic [3:0] LS_SEL_SB  = 4'h8;
    localparam logic [3:0] LS_SEL_SH  = 4'h9;
    localparam logic [3:0] LS_SEL_SW  = 4'hA;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } lsu_state_e;

    function automatic logic [1:0] ls_size(input logic [3:0] sel);
        case (sel)
            LS_SEL_LB, LS_SEL_LBU, LS_SEL_SB: ls_size = SIZE_BYTE;
            LS_SEL_LH, LS_SEL_LHU, LS_SEL_SH: ls_size = SIZE_HALF;
            default:                          ls_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu1_c_align.sv
// Combinational lane alignment: store strobes/data replication and load extract/extend.
module lsu_align_c
    import lsu1_c_pkg::*;
(
    input  logic [3:0]  i_sel,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rt,
    input  logic [31:0] i_rdata,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    assign o_size = ls_size(i_sel);

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_rt;
        o_ldata = i_rdata;
        case (i_sel)
            LS_SEL_SB: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rt[7:0]}};
            end
            LS_SEL_SH: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rt[15:0]}};
            end
            LS_SEL_SW:  o_wstrb = 4'b1111;
            LS_SEL_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
            LS_SEL_LBU: o_ldata = {24'd0, w_byte};
            LS_SEL_LH:  o_ldata = {{16{w_half[15]}}, w_half};
            LS_SEL_LHU: o_ldata = {16'd0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu1_c.sv
// Memory-access stage: holds the EX op, runs the bus handshake FSM and produces the writeback result.
module lsu1_c
    import lsu1_c_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_has_exception,
    input  logic        ex_ls_ena,
    input  logic [3:0]  ex_ls_sel,
    input  logic [31:0] ex_ls_addr,
    input  logic [31:0] ex_rt_data,
    input  logic [31:0] ex_alu_res,
    input  logic        ex_w_reg_ena,
    input  logic [4:0]  ex_w_reg_dst,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        lsu1_stall_req,
    output logic        lsu1_valid,
    output logic        lsu1_w_reg_ena,
    output logic [4:0]  lsu1_w_reg_dst,
    output logic [31:0] lsu1_w_data
);
    lsu_state_e  r_state, w_state_nxt;
    logic        r_valid, r_has_exc, r_ls_ena, r_w_ena;
    logic [3:0]  r_ls_sel;
    logic [31:0] r_ls_addr, r_rt, r_alu, r_rdata;
    logic [4:0]  r_w_dst;

    logic        w_mem, w_pass, w_done, w_store, w_resp;
    logic [31:0] w_ldata;

    assign w_mem   = r_valid & r_ls_ena & ~r_has_exc;
    assign w_pass  = (r_state == ST_IDLE) & r_valid & ~w_mem;
    assign w_done  = (r_state == ST_DONE);
    assign w_store = r_ls_sel[3];
    assign w_resp  = data_data_ok & (((r_state == ST_REQ) & data_addr_ok) | (r_state == ST_WAIT));

    assign lsu1_stall_req = (r_state == ST_REQ) | (r_state == ST_WAIT) | (r_state == ST_CANCEL)
                          | ((r_state == ST_IDLE) & w_mem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_has_exc <= 1'b0;
            r_ls_ena  <= 1'b0;
            r_ls_sel  <= 4'd0;
            r_ls_addr <= 32'd0;
            r_rt      <= 32'd0;
            r_alu     <= 32'd0;
            r_w_ena   <= 1'b0;
            r_w_dst   <= 5'd0;
            r_rdata   <= 32'd0;
        end else begin
            // Flush must also kill an op that is being held by the stall.
            if (flush)
                r_valid <= 1'b0;
            else if (!lsu1_stall_req)
                r_valid <= ex_valid;
            if (!lsu1_stall_req) begin
                r_has_exc <= ex_has_exception;
                r_ls_ena  <= ex_ls_ena;
                r_ls_sel  <= ex_ls_sel;
                r_ls_addr <= ex_ls_addr;
                r_rt      <= ex_rt_data;
                r_alu     <= ex_alu_res;
                r_w_ena   <= ex_w_reg_ena;
                r_w_dst   <= ex_w_reg_dst;
            end
            if (w_resp)
                r_rdata <= data_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:
                if (w_mem && !flush) w_state_nxt = ST_REQ;
            ST_REQ:
                if (flush) begin
                    // Accepted but unanswered requests must still drain their response.
                    if (data_addr_ok && !data_data_ok) w_state_nxt = ST_CANCEL;
                    else                               w_state_nxt = ST_IDLE;
                end else if (data_addr_ok) begin
                    w_state_nxt = data_data_ok ? ST_DONE : ST_WAIT;
                end
            ST_WAIT:
                if (data_data_ok)  w_state_nxt = flush ? ST_IDLE : ST_DONE;
                else if (flush)    w_state_nxt = ST_CANCEL;
            ST_DONE:
                w_state_nxt = ST_IDLE;
            ST_CANCEL:
                if (data_data_ok) w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    lsu_align_c u_align (
        .i_sel     (r_ls_sel),
        .i_addr_lo (r_ls_addr[1:0]),
        .i_rt      (r_rt),
        .i_rdata   (r_rdata),
        .o_size    (data_size),
        .o_wstrb   (data_wstrb),
        .o_wdata   (data_wdata),
        .o_ldata   (w_ldata)
    );

    assign data_req  = (r_state == ST_REQ);
    assign data_wr   = w_store;
    assign data_addr = r_ls_addr;

    assign lsu1_valid     = (w_pass | w_done) & ~flush;
    assign lsu1_w_reg_ena = lsu1_valid & r_w_ena & ~r_has_exc & ~(w_done & w_store);
    assign lsu1_w_reg_dst = r_w_dst;
    assign lsu1_w_data    = (w_done && !w_store) ? w_ldata : r_alu;

endmodule

// File: tb/tb_lsu1_c.sv
// Directed bench for lsu1_c: loads, stores, bus back-pressure, flush cancel, exception pass and reset.
module tb_lsu1_c;
    import lsu1_c_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        ex_valid, ex_has_exception, ex_ls_ena, ex_w_reg_ena;
    logic [3:0]  ex_ls_sel;
    logic [31:0] ex_ls_addr, ex_rt_data, ex_alu_res;
    logic [4:0]  ex_w_reg_dst;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        lsu1_stall_req, lsu1_valid, lsu1_w_reg_ena;
    logic [4:0]  lsu1_w_reg_dst;
    logic [31:0] lsu1_w_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu1_c dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_has_exception(ex_has_exception), .ex_ls_ena(ex_ls_ena),
        .ex_ls_sel(ex_ls_sel), .ex_ls_addr(ex_ls_addr), .ex_rt_data(ex_rt_data),
        .ex_alu_res(ex_alu_res), .ex_w_reg_ena(ex_w_reg_ena), .ex_w_reg_dst(ex_w_reg_dst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .lsu1_stall_req(lsu1_stall_req), .lsu1_valid(lsu1_valid),
        .lsu1_w_reg_ena(lsu1_w_reg_ena), .lsu1_w_reg_dst(lsu1_w_reg_dst), .lsu1_w_data(lsu1_w_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs change and outputs settle here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic v, input logic exc, input logic ena, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] alu,
                          input logic wena, input logic [4:0] dst);
        ex_valid = v; ex_has_exception = exc; ex_ls_ena = ena; ex_ls_sel = sel;
        ex_ls_addr = addr; ex_rt_data = rt; ex_alu_res = alu; ex_w_reg_ena = wena; ex_w_reg_dst = dst;
    endtask

    task automatic ex_idle();
        set_ex(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // addr_ok in the first REQ cycle, data_ok in the first WAIT cycle.
    task automatic mem_op(input string tag, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input logic [31:0] alu,
                          input logic wena, input logic [4:0] dst, input logic [3:0] exp_strb,
                          input logic [31:0] exp_bwdata, input logic [1:0] exp_size,
                          input logic [31:0] exp_res, input logic exp_wena);
        int stalls;
        stalls = 0;
        set_ex(1'b1, 1'b0, 1'b1, sel, addr, rt, alu, wena, dst);
        cyc(); ex_idle(); #1;
        stalls += int'(lsu1_stall_req);
        chk({tag, "_idle_req"}, {31'd0, data_req}, 32'd0);
        cyc(); #1;
        stalls += int'(lsu1_stall_req);
        chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
        chk({tag, "_addr"}, data_addr, addr);
        chk({tag, "_wr"}, {31'd0, data_wr}, {31'd0, sel[3]});
        chk({tag, "_size"}, {30'd0, data_size}, {30'd0, exp_size});
        chk({tag, "_wstrb"}, {28'd0, data_wstrb}, {28'd0, exp_strb});
        if (sel[3]) chk({tag, "_wdata"}, data_wdata, exp_bwdata);
        data_addr_ok = 1'b1;
        cyc(); data_addr_ok = 1'b0; #1;
        stalls += int'(lsu1_stall_req);
        chk({tag, "_wait_req"}, {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = rdata;
        cyc(); data_data_ok = 1'b0; data_rdata = 32'd0; #1;
        stalls += int'(lsu1_stall_req);
        chk({tag, "_valid"}, {31'd0, lsu1_valid}, 32'd1);
        chk({tag, "_wdat"}, lsu1_w_data, exp_res);
        chk({tag, "_wena"}, {31'd0, lsu1_w_reg_ena}, {31'd0, exp_wena});
        chk({tag, "_stall_cycles"}, stalls, 32'd3);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        ex_idle();
        #3;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_valid", {31'd0, lsu1_valid}, 32'd0);
        chk("rst_stall", {31'd0, lsu1_stall_req}, 32'd0);
        chk("rst_wdata", lsu1_w_data, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        mem_op("lw", LS_SEL_LW, 32'h8000_0004, 32'd0, 32'h1234_5678, 32'hAAAA, 1'b1, 5'd5,
               4'b0000, 32'd0, SIZE_WORD, 32'h1234_5678, 1'b1);
        mem_op("lb", LS_SEL_LB, 32'h8000_0003, 32'd0, 32'h80FF_FFFF, 32'd0, 1'b1, 5'd6,
               4'b0000, 32'd0, SIZE_BYTE, 32'hFFFF_FF80, 1'b1);
        mem_op("lbu", LS_SEL_LBU, 32'h8000_0003, 32'd0, 32'h80FF_FFFF, 32'd0, 1'b1, 5'd6,
               4'b0000, 32'd0, SIZE_BYTE, 32'h0000_0080, 1'b1);
        mem_op("lh", LS_SEL_LH, 32'h8000_0002, 32'd0, 32'h8001_1234, 32'd0, 1'b1, 5'd7,
               4'b0000, 32'd0, SIZE_HALF, 32'hFFFF_8001, 1'b1);
        mem_op("lhu", LS_SEL_LHU, 32'h8000_0002, 32'd0, 32'h8001_1234, 32'd0, 1'b1, 5'd7,
               4'b0000, 32'd0, SIZE_HALF, 32'h0000_8001, 1'b1);
        mem_op("sh", LS_SEL_SH, 32'h8000_0002, 32'h0000_BEEF, 32'd0, 32'h8000_0002, 1'b0, 5'd0,
               4'b1100, 32'hBEEF_BEEF, SIZE_HALF, 32'h8000_0002, 1'b0);
        mem_op("sb", LS_SEL_SB, 32'h8000_0003, 32'h0000_00A5, 32'd0, 32'h8000_0003, 1'b0, 5'd0,
               4'b1000, 32'hA5A5_A5A5, SIZE_BYTE, 32'h8000_0003, 1'b0);
        mem_op("sw", LS_SEL_SW, 32'h8000_0008, 32'hCAFE_F00D, 32'd0, 32'h8000_0008, 1'b0, 5'd0,
               4'b1111, 32'hCAFE_F00D, SIZE_WORD, 32'h8000_0008, 1'b0);
        cyc(); #1;
        chk("post_idle_valid", {31'd0, lsu1_valid}, 32'd0);

        // Back-to-back LW then SW with addr_ok withheld for 4 REQ cycles.
        set_ex(1'b1, 1'b0, 1'b1, LS_SEL_LW, 32'h8000_0010, 32'd0, 32'h11, 1'b1, 5'd3);
        cyc();
        set_ex(1'b1, 1'b0, 1'b1, LS_SEL_SW, 32'h8000_0020, 32'hDEAD_BEEF, 32'h22, 1'b0, 5'd0);
        #1; chk("b2b_stall", {31'd0, lsu1_stall_req}, 32'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b2b_hold_req", {31'd0, data_req}, 32'd1);
            chk("b2b_hold_addr", data_addr, 32'h8000_0010);
            chk("b2b_hold_wr", {31'd0, data_wr}, 32'd0);
            cyc();
        end
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
        #1; chk("b2b_last_addr", data_addr, 32'h8000_0010);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0; #1;
        chk("b2b_lw_valid", {31'd0, lsu1_valid}, 32'd1);
        chk("b2b_lw_data", lsu1_w_data, 32'h0BAD_F00D);
        chk("b2b_lw_dst", {27'd0, lsu1_w_reg_dst}, 32'd3);
        cyc(); ex_idle(); #1;
        chk("b2b_sw_pending", {31'd0, lsu1_stall_req}, 32'd1);
        cyc(); #1;
        chk("b2b_sw_addr", data_addr, 32'h8000_0020);
        chk("b2b_sw_wr", {31'd0, data_wr}, 32'd1);
        chk("b2b_sw_wdata", data_wdata, 32'hDEAD_BEEF);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
        chk("b2b_sw_valid", {31'd0, lsu1_valid}, 32'd1);
        chk("b2b_sw_wena", {31'd0, lsu1_w_reg_ena}, 32'd0);

        // Flush while waiting for data: response arrives later and is discarded.
        set_ex(1'b1, 1'b0, 1'b1, LS_SEL_LW, 32'h8000_0030, 32'd0, 32'd0, 1'b1, 5'd9);
        cyc(); ex_idle();
        cyc(); data_addr_ok = 1'b1;
        cyc(); data_addr_ok = 1'b0; flush = 1'b1;
        cyc(); flush = 1'b0; #1;
        chk("fl_cancel_stall", {31'd0, lsu1_stall_req}, 32'd1);
        chk("fl_cancel_valid", {31'd0, lsu1_valid}, 32'd0);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000; #1;
        chk("fl_resp_valid", {31'd0, lsu1_valid}, 32'd0);
        chk("fl_resp_stall", {31'd0, lsu1_stall_req}, 32'd1);
        cyc(); data_data_ok = 1'b0; #1;
        chk("fl_idle_stall", {31'd0, lsu1_stall_req}, 32'd0);
        chk("fl_idle_valid", {31'd0, lsu1_valid}, 32'd0);
        chk("fl_idle_wena", {31'd0, lsu1_w_reg_ena}, 32'd0);

        // Excepting SW passes through without a bus request; then a plain ALU op.
        set_ex(1'b1, 1'b1, 1'b1, LS_SEL_SW, 32'h8000_0041, 32'h1, 32'h55, 1'b1, 5'd4);
        cyc();
        set_ex(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'hCAFE, 1'b1, 5'd7);
        #1;
        chk("exc_req", {31'd0, data_req}, 32'd0);
        chk("exc_valid", {31'd0, lsu1_valid}, 32'd1);
        chk("exc_wena", {31'd0, lsu1_w_reg_ena}, 32'd0);
        chk("exc_wdata", lsu1_w_data, 32'h55);
        chk("exc_stall", {31'd0, lsu1_stall_req}, 32'd0);
        cyc(); ex_idle(); #1;
        chk("alu_req", {31'd0, data_req}, 32'd0);
        chk("alu_valid", {31'd0, lsu1_valid}, 32'd1);
        chk("alu_wena", {31'd0, lsu1_w_reg_ena}, 32'd1);
        chk("alu_wdata", lsu1_w_data, 32'hCAFE);
        cyc(); #1;
        chk("alu_done_valid", {31'd0, lsu1_valid}, 32'd0);

        // Asynchronous reset in the middle of a request.
        set_ex(1'b1, 1'b0, 1'b1, LS_SEL_SW, 32'h8000_0050, 32'h1234, 32'h77, 1'b0, 5'd2);
        cyc(); ex_idle();
        cyc(); #1;
        chk("rreq_req", {31'd0, data_req}, 32'd1);
        rst = 1'b1; #1;
        chk("rreq_req_clr", {31'd0, data_req}, 32'd0);
        chk("rreq_stall_clr", {31'd0, lsu1_stall_req}, 32'd0);
        chk("rreq_addr_clr", data_addr, 32'd0);
        chk("rreq_wdata_clr", data_wdata, 32'd0);
        chk("rreq_wr_clr", {31'd0, data_wr}, 32'd0);
        cyc(); rst = 1'b0;
        cyc(); #1;
        chk("rreq_after_req", {31'd0, data_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
